// File: rtl/wb_openram_bridge.sv
// Wishbone classic slave bridging a Caravel user address window onto port 0
// (1RW) of an OpenRAM SRAM macro with 32-bit words and a byte write mask.
//
// Ports:
//   wb_clk_i, wb_rst_n_i          shared clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/sel_i    Wishbone request
//   wbs_adr_i/dat_i               byte address, write data
//   wbs_ack_o/err_o/dat_o         registered one-cycle response, read data
//   sram_csb0/web0/wmask0         SRAM port 0 controls (csb/web active low)
//   sram_addr0/din0/dout0         SRAM word address, write data, read data
//
// Build option: define WB_OPENRAM_ERR_EN to answer out-of-window accesses
// with wbs_err_o; otherwise they are acked (reads return 0, writes dropped).

module wb_openram_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RWAIT  = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam logic [32:0] WINDOW     = 33'd4 << ADDR_WIDTH;
    localparam logic [1:0]  RWAIT_LOAD = 2'(READ_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic        we_q;
    logic [32:0] offset;
    logic        in_range;
    logic        req;

    // 33-bit subtraction: bit 32 flags addresses below the base.
    assign offset   = {1'b0, wbs_adr_i} - {1'b0, BASE_ADDR};
    assign in_range = !offset[32] && (offset < WINDOW);

    // A response still on the bus means the master has not yet seen it;
    // its stb must not start a second access.
    assign req = wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o;

`ifdef WB_OPENRAM_ERR_EN
    logic err_q;
    assign wbs_err_o = err_q;
`else
    assign wbs_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
`ifdef WB_OPENRAM_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        if (in_range) begin
                            sram_csb0   <= 1'b0;
                            sram_web0   <= ~wbs_we_i;
                            sram_wmask0 <= wbs_we_i ? wbs_sel_i : 4'b0000;
                            sram_din0   <= wbs_dat_i;
                            sram_addr0  <= offset[ADDR_WIDTH+1:2];
                            we_q        <= wbs_we_i;
                            state       <= S_ACCESS;
                        end else begin
                            state <= S_ACK;
`ifdef WB_OPENRAM_ERR_EN
                            err_q <= 1'b1;
`else
                            wbs_ack_o <= 1'b1;
                            if (!wbs_we_i) begin
                                wbs_dat_o <= '0;
                            end
`endif
                        end
                    end
                end
                S_ACCESS: begin
                    // SRAM samples at this edge; the access completes even
                    // if the master has abandoned the cycle.
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    if (!wbs_cyc_i) begin
                        state <= S_IDLE;
                    end else if (we_q) begin
                        wbs_ack_o <= 1'b1;
                        state     <= S_ACK;
                    end else begin
                        cnt   <= RWAIT_LOAD;
                        state <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt == 2'd0) begin
                        wbs_dat_o <= sram_dout0;
                        wbs_ack_o <= 1'b1;
                        state     <= S_ACK;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_ACK: begin
                    wbs_ack_o <= 1'b0;
`ifdef WB_OPENRAM_ERR_EN
                    err_q     <= 1'b0;
`endif
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_openram_bridge.sv
// Directed testbench for wb_openram_bridge: instance 0 with READ_LATENCY=1,
// instance 1 with READ_LATENCY=3, each backed by a behavioural SRAM.

module tb_wb_openram_bridge;

`ifdef WB_OPENRAM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc [2];
    logic        stb [2];
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic        ack [2];
    logic        err [2];
    logic [31:0] dato [2];
    logic        csb [2];
    logic        web [2];
    logic [3:0]  wmask [2];
    logic [7:0]  addr [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wb_openram_bridge #(.READ_LATENCY(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .wbs_dat_o(dato[0]),
        .sram_csb0(csb[0]), .sram_web0(web[0]), .sram_wmask0(wmask[0]),
        .sram_addr0(addr[0]), .sram_din0(din[0]), .sram_dout0(dout[0])
    );

    wb_openram_bridge #(.READ_LATENCY(3)) u_dut3 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .wbs_dat_o(dato[1]),
        .sram_csb0(csb[1]), .sram_web0(web[1]), .sram_wmask0(wmask[1]),
        .sram_addr0(addr[1]), .sram_din0(din[1]), .sram_dout0(dout[1])
    );

    // Behavioural SRAM: read data is valid only RL cycles after the
    // sampling edge; any other time it shows a poison pattern.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        localparam int RL = (g == 0) ? 1 : 3;
        logic [31:0] mem [256];
        logic [31:0] pd [3];
        logic [2:0]  pv;
        always @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
                pv <= '0;
            end else begin
                if (!csb[g] && !web[g])
                    for (int b = 0; b < 4; b++)
                        if (wmask[g][b])
                            mem[addr[g]][8*b +: 8] <= din[g][8*b +: 8];
                pv    <= {pv[1:0], !csb[g] && web[g]};
                pd[0] <= mem[addr[g]];
                pd[1] <= pd[0];
                pd[2] <= pd[1];
            end
        end
        assign dout[g] = pv[RL-1] ? pd[RL-1] : 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic we_v, input logic [3:0] sel_v,
                        input logic [31:0] adr_v, input logic [31:0] dat_v,
                        output int lat, output logic a_s, output logic e_s,
                        output logic [31:0] rd, output logic hit,
                        output logic [7:0] a, output logic [3:0] m);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1;
        we = we_v; sel = sel_v; adr = adr_v; dat = dat_v;
        lat = -1; a_s = 0; e_s = 0; rd = '0; hit = 0; a = '0; m = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!csb[d]) begin
                hit = 1'b1; a = addr[d]; m = wmask[d];
            end
            if (ack[d] || err[d]) begin
                lat = k; a_s = ack[d]; e_s = err[d]; rd = dato[d];
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic drop_req(input int d, input logic we_v,
                            input logic [31:0] adr_v, input logic [31:0] dat_v,
                            input int hold, output logic seen);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1;
        we = we_v; sel = 4'hF; adr = adr_v; dat = dat_v;
        @(posedge clk);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        cyc[d] = 1'b0; stb[d] = 1'b0;
        seen = ack[d] | err[d];
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            seen |= ack[d] | err[d];
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        rsp_err;
        int          lat;
        logic [31:0] rd;
        logic        hit;
        logic [7:0]  a;
        logic [3:0]  m;
    } vec_t;

    vec_t vt [14];

    initial begin
        int          lat;
        logic        a_s, e_s, hit, seen;
        logic [31:0] rd;
        logic [7:0]  a;
        logic [3:0]  m;
        logic [31:0] r0, r9;

        r0 = ERR ? 32'hDEADABEF : 32'h0;
        r9 = ERR ? 32'h12345678 : 32'h0;
        vt[0]  = '{1'b1, 4'hF, 32'h3000_0010, 32'hDEADBEEF, 1'b0, 1, 32'h0,         1'b1, 8'h04, 4'hF};
        vt[1]  = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,        1'b0, 2, 32'hDEADBEEF, 1'b1, 8'h04, 4'h0};
        vt[2]  = '{1'b1, 4'h2, 32'h3000_0010, 32'h0000AB00, 1'b0, 1, 32'hDEADBEEF, 1'b1, 8'h04, 4'h2};
        vt[3]  = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,        1'b0, 2, 32'hDEADABEF, 1'b1, 8'h04, 4'h0};
        vt[4]  = '{1'b0, 4'hF, 32'h3000_0400, 32'h0,        ERR,  0, r0,           1'b0, 8'h00, 4'h0};
        vt[5]  = '{1'b1, 4'hF, 32'h3000_03FC, 32'h12345678, 1'b0, 1, r0,           1'b1, 8'hFF, 4'hF};
        vt[6]  = '{1'b0, 4'hF, 32'h3000_03FC, 32'h0,        1'b0, 2, 32'h12345678, 1'b1, 8'hFF, 4'h0};
        vt[7]  = '{1'b1, 4'h0, 32'h3000_03FC, 32'hFFFFFFFF, 1'b0, 1, 32'h12345678, 1'b1, 8'hFF, 4'h0};
        vt[8]  = '{1'b0, 4'hF, 32'h3000_03FC, 32'h0,        1'b0, 2, 32'h12345678, 1'b1, 8'hFF, 4'h0};
        vt[9]  = '{1'b0, 4'hF, 32'h2FFF_FFFC, 32'h0,        ERR,  0, r9,           1'b0, 8'h00, 4'h0};
        vt[10] = '{1'b1, 4'h9, 32'h3000_0000, 32'hA1B2C3D4, 1'b0, 1, r9,           1'b1, 8'h00, 4'h9};
        vt[11] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,        1'b0, 2, 32'hA10000D4, 1'b1, 8'h00, 4'h0};
        vt[12] = '{1'b1, 4'hF, 32'h3000_0400, 32'h55555555, ERR,  0, 32'hA10000D4, 1'b0, 8'h00, 4'h0};
        vt[13] = '{1'b0, 4'hF, 32'h3000_0010, 32'h0,        1'b0, 2, 32'hDEADABEF, 1'b1, 8'h04, 4'h0};

        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d ack/err", d), {ack[d], err[d]}, 0);
            chk($sformatf("rst%0d dat_o", d), dato[d], 0);
            chk($sformatf("rst%0d csb/web", d), {csb[d], web[d]}, 2'b11);
            chk($sformatf("rst%0d mask/addr", d), {wmask[d], addr[d]}, 0);
            chk($sformatf("rst%0d din", d), din[d], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            xfer(0, vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat,
                 lat, a_s, e_s, rd, hit, a, m);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("v%0d ack/err", i), {a_s, e_s},
                {~vt[i].rsp_err, vt[i].rsp_err});
            chk($sformatf("v%0d dat_o", i), rd, vt[i].rd);
            chk($sformatf("v%0d sram touched", i), hit, vt[i].hit);
            if (vt[i].hit) begin
                chk($sformatf("v%0d sram_addr0", i), a, vt[i].a);
                chk($sformatf("v%0d wmask0", i), m, vt[i].m);
            end
        end

        // Write abandoned in ACCESS still lands in the SRAM.
        drop_req(0, 1'b1, 32'h3000_0030, 32'h77777777, 0, seen);
        chk("drop write no ack", seen, 0);
        xfer(0, 1'b0, 4'hF, 32'h3000_0030, 32'h0, lat, a_s, e_s, rd, hit, a, m);
        chk("drop write readback", rd, 32'h77777777);
        chk("drop write rd latency", 64'(lat), 2);

        // Reset asserted while a write is in ACCESS.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1;
        we = 1'b1; sel = 4'hF; adr = 32'h3000_0020; dat = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        chk("abort in access", csb[0], 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        chk("abort ack/err", {ack[0], err[0]}, 0);
        chk("abort dat_o", dato[0], 0);
        chk("abort csb/web", {csb[0], web[0]}, 2'b11);
        chk("abort mask/addr", {wmask[0], addr[0]}, 0);
        chk("abort din", din[0], 0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            seen |= ack[0] | err[0];
        end
        chk("abort no late ack", seen, 0);
        xfer(0, 1'b1, 4'hF, 32'h3000_0020, 32'h2222_2222, lat, a_s, e_s, rd, hit, a, m);
        chk("post-abort write latency", 64'(lat), 1);

        // READ_LATENCY=3 instance.
        xfer(1, 1'b1, 4'hF, 32'h3000_0010, 32'hDEADBEEF, lat, a_s, e_s, rd, hit, a, m);
        chk("rl3 write latency", 64'(lat), 1);
        chk("rl3 write ack", a_s, 1);
        xfer(1, 1'b0, 4'hF, 32'h3000_0010, 32'h0, lat, a_s, e_s, rd, hit, a, m);
        chk("rl3 read latency", 64'(lat), 4);
        chk("rl3 read data", rd, 32'hDEADBEEF);
        chk("rl3 read addr", a, 8'h04);

        // Read abandoned in RWAIT: no response, data held, FSM recovers.
        drop_req(1, 1'b0, 32'h3000_0010, 32'h0, 1, seen);
        chk("rwait drop no ack", seen, 0);
        chk("rwait drop dat_o", dato[1], 32'hDEADBEEF);
        chk("rwait drop csb", csb[1], 1);
        xfer(1, 1'b1, 4'hF, 32'h3000_0014, 32'h0BADF00D, lat, a_s, e_s, rd, hit, a, m);
        chk("rwait next write latency", 64'(lat), 1);
        xfer(1, 1'b0, 4'hF, 32'h3000_0014, 32'h0, lat, a_s, e_s, rd, hit, a, m);
        chk("rwait next read latency", 64'(lat), 4);
        chk("rwait next read data", rd, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
